// File: rtl/ysyx_22040895_mdu_ctrl_if.sv
// Pipeline <-> MDU handshake bundle: request/opcode/operands/flush in, stall/strobe/result out.
// Latency: none (plain wires); the sequencer defines all timing.
// Backpressure: busy_o_mdu is the stall request; there is no other flow control.
interface ysyx_22040895_mdu_ctrl_if #(
    parameter int XLEN = 64
);
    logic            start_i_mdu;
    logic [3:0]      mduop_i_mdu;
    logic [XLEN-1:0] src1_i_mdu;
    logic [XLEN-1:0] src2_i_mdu;
    logic            flush_i_mdu;
    logic            busy_o_mdu;
    logic            valid_o_mdu;
    logic [XLEN-1:0] result_o_mdu;

    // Pipeline side.
    modport master (
        output start_i_mdu, mduop_i_mdu, src1_i_mdu, src2_i_mdu, flush_i_mdu,
        input  busy_o_mdu, valid_o_mdu, result_o_mdu
    );

    // Sequencer side.
    modport slave (
        input  start_i_mdu, mduop_i_mdu, src1_i_mdu, src2_i_mdu, flush_i_mdu,
        output busy_o_mdu, valid_o_mdu, result_o_mdu
    );
endinterface

// File: rtl/ysyx_22040895_mdu_ctrl.sv
// Iterative multiply (shift-add) / 32-bit signed restoring divide sequencer for the execute stage.
// Latency from accept: mul 65, mulw 33, divw/remw 34, divide special cases 1 cycle.
// Backpressure: busy_o_mdu stalls the pipeline from accept until DONE; valid_o_mdu is a 1-cycle strobe.
// Ports: clk, rst (async active-low), mdu (slave modport of ysyx_22040895_mdu_ctrl_if).
module ysyx_22040895_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22040895_mdu_ctrl_if.slave  mdu
);
    localparam logic [3:0] OP_MUL  = 4'b0001;
    localparam logic [3:0] OP_MULW = 4'b0101;
    localparam logic [3:0] OP_DIVW = 4'b1001;
    localparam logic [3:0] OP_REMW = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // The multiply registers are reused by the divider:
    //   acc    -> partial remainder (low 32 bits)
    //   mplier -> dividend shifting out / quotient shifting in (low 32 bits)
    //   mcand  -> |divisor| (low 32 bits)
    state_e          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic            word_q, word_d;
    logic            rem_op_q, rem_op_d;
    logic            neg1_q, neg1_d;
    logic            neg2_q, neg2_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    // Opcode decode and accept
    logic is_mul, is_mulw, is_divw, is_remw, op_legal, accept;

    // Divide operand preparation
    logic [31:0] src1_w, src2_w, abs1, abs2;
    logic        sgn1, sgn2, div_zero, div_ovf;

    // Datapath steps
    logic [XLEN-1:0] mul_acc;
    logic [32:0]     div_shift, div_diff;
    logic [31:0]     quot, rem, fix_val;

    always_comb begin
        is_mul   = (mdu.mduop_i_mdu == OP_MUL);
        is_mulw  = (mdu.mduop_i_mdu == OP_MULW);
        is_divw  = (mdu.mduop_i_mdu == OP_DIVW);
        is_remw  = (mdu.mduop_i_mdu == OP_REMW);
        op_legal = is_mul | is_mulw | is_divw | is_remw;
        accept   = (state_q == S_IDLE) & mdu.start_i_mdu & op_legal & ~mdu.flush_i_mdu;

        src1_w   = mdu.src1_i_mdu[31:0];
        src2_w   = mdu.src2_i_mdu[31:0];
        sgn1     = src1_w[31];
        sgn2     = src2_w[31];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
        abs1     = sgn1 ? -src1_w : src1_w;
        abs2     = sgn2 ? -src2_w : src2_w;
        div_zero = (src2_w == 32'h0);
        div_ovf  = (src1_w == 32'h8000_0000) && (src2_w == 32'hFFFF_FFFF);

        mul_acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        // Restoring step: the shifted remainder can reach 33 bits, the divisor is at most 2^31,
        // so bit 32 of the difference is a clean "negative" flag.
        div_shift = {acc_q[31:0], mplier_q[31]};
        div_diff  = div_shift - {1'b0, mcand_q[31:0]};

        quot    = mplier_q[31:0];
        rem     = acc_q[31:0];
        fix_val = rem_op_q ? (neg1_q ? -rem : rem)
                           : ((neg1_q ^ neg2_q) ? -quot : quot);
    end

    // Stall request; forced low while reset is held so a pending start cannot leak out.
    assign mdu.busy_o_mdu   = rst & (accept | (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX));
    assign mdu.valid_o_mdu  = valid_q;
    assign mdu.result_o_mdu = result_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        word_d   = word_q;
        rem_op_d = rem_op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d   = is_mulw;
                    rem_op_d = is_remw;
                    neg1_d   = sgn1;
                    neg2_d   = sgn2;
                    acc_d    = '0;
                    if (is_mul) begin
                        mcand_d  = mdu.src1_i_mdu;
                        mplier_d = mdu.src2_i_mdu;
                        cnt_d    = 7'(XLEN);
                        state_d  = S_MUL;
                    end else if (is_mulw) begin
                        mcand_d  = XLEN'(src1_w);
                        mplier_d = XLEN'(src2_w);
                        cnt_d    = 7'd32;
                        state_d  = S_MUL;
                    end else if (div_zero) begin
                        result_d = is_remw ? sext32(src1_w) : '1;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = is_remw ? '0 : sext32(32'h8000_0000);
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        mcand_d  = XLEN'(abs2);
                        mplier_d = XLEN'(abs1);
                        cnt_d    = 7'd32;
                        state_d  = S_DIV;
                    end
                end
            end

            S_MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    // Last iteration: capture the freshly summed product directly.
                    result_d = word_q ? sext32(mul_acc[31:0]) : mul_acc;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DIV: begin
                if (!div_diff[32]) begin
                    acc_d = XLEN'(div_diff[31:0]);
                end else begin
                    acc_d = XLEN'(div_shift[31:0]);
                end
                mplier_d = XLEN'({mplier_q[30:0], ~div_diff[32]});
                cnt_d    = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = sext32(fix_val);
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything: no strobe and the previous result is kept.
        if (mdu.flush_i_mdu) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            word_q   <= 1'b0;
            rem_op_q <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            rem_op_q <= rem_op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// File: doc/ysyx_22040895_mdu_ctrl.md
# ysyx_22040895_mdu_ctrl

Multi-cycle multiply/divide sequencer for the execute stage. It accepts the 4-bit MDU opcode produced by the control unit along with two register operands, and runs an iterative shift-add multiplier or restoring divider. While the operation runs it holds a stall request to the pipeline, then presents a one-cycle result strobe.

## Interface

Parameters:
- XLEN, 64, operand and result width. Word operations use the low 32 bits.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i_mdu  input  1  request qualifier; sampled only in IDLE.
- mduop_i_mdu  input  4  opcode: 0001 mul, 0101 mulw, 1001 divw, 1101 remw. Any other value is no operation.
- src1_i_mdu  input  XLEN  rs1 operand (multiplicand or dividend).
- src2_i_mdu  input  XLEN  rs2 operand (multiplier or divisor).
- flush_i_mdu  input  1  abort the current operation; has priority over everything except reset.
- busy_o_mdu  output  1  pipeline stall request.
- valid_o_mdu  output  1  result strobe, high for one cycle.
- result_o_mdu  output  XLEN  result; held stable from DONE until the next accept.

## Operation

- States: IDLE, MUL, DIV, FIX, DONE.
- Accept condition: IDLE, start_i_mdu=1, legal opcode, flush_i_mdu=0. On accept, the block latches the operands and the opcode, loads the iteration counter, and selects the next state.
- mul (low 64 bits of product):
  - MUL runs 64 iterations, one per cycle.
  - Each cycle: if multiplier bit0=1, acc += multiplicand. Then the multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - Operands are treated as unsigned. This gives correct low bits for signed inputs.
- mulw: same datapath on low 32 bits, 32 iterations. Result is bits[31:0] of the product, sign-extended to 64 bits.
- divw/remw (signed 32-bit):
  - On accept, latch |src1[31:0]| and |src2[31:0]| plus the two sign bits.
  - DIV runs 32 restoring iterations: shift {rem,quot} left by 1, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - FIX (1 cycle): negate the quotient if the signs differ; negate the remainder if the dividend is negative. Sign-extend bit 31 of the selected value.
- Special cases are detected on accept and go directly to DONE with no iteration:
  - Divisor[31:0]=0: divw returns all ones; remw returns sext(src1[31:0]).
  - src1[31:0]=0x80000000 and src2[31:0]=0xFFFFFFFF: divw returns 0xFFFFFFFF80000000; remw returns 0.
- DONE: valid_o_mdu=1 for one cycle, then IDLE.
- busy_o_mdu = (accept condition true this cycle) OR (state in MUL, DIV, FIX).
  - busy is low in DONE and IDLE, so the stalled instruction is released in the DONE cycle and captures result_o_mdu.
- Counter: 7 bits. Counts down to 1; the iteration state exits when counter==1 after that cycle's iteration.

## Timing

- Reset (rst=0, asynchronous): state=IDLE, counter=0, result_o_mdu=0, valid_o_mdu=0, busy_o_mdu=0. busy is forced 0 while rst=0 regardless of start.
- Accept in cycle T gives valid_o_mdu high in:
  - mul: T+65
  - mulw: T+33
  - divw/remw: T+34 (DIV T+1..T+32, FIX T+33)
  - special-case divide: T+1
- start_i_mdu is ignored in MUL, DIV, FIX, and DONE. A back-to-back request is accepted at the earliest in the cycle after DONE.
- flush_i_mdu=1 in any state: next state is IDLE, no valid strobe, and result_o_mdu keeps its previous value.
  - If flush is high in the cycle of an accept, the request is not accepted and busy is low.
  - If flush is high in DONE, the strobe in that cycle still occurs, because valid is already registered.
- Reset mid-operation: immediate IDLE, all outputs return to reset values, and no strobe.
- Illegal or zero opcode with start=1: busy stays 0 and no state change.

## Test plan

- mul, src1=3, src2=0xFFFFFFFFFFFFFFFB (-5), accepted at T: busy high T..T+64; at T+65 valid=1, result=0xFFFFFFFFFFFFFFF1, busy=0.
- mulw, src1=0x7FFFFFFF, src2=2: valid at T+33, result=0xFFFFFFFFFFFFFFFE.
- divw/remw, src1=-7, src2=2:
  - divw gives result=0xFFFFFFFFFFFFFFFD at T+34.
  - remw gives 0xFFFFFFFFFFFFFFFF at T+34.
  - src1=100, src2=7 gives divw 14 and remw 2.
- Special cases, each with valid at T+1:
  - divw 5/0 gives 0xFFFFFFFFFFFFFFFF.
  - remw 5/0 gives 5.
  - divw 0x80000000/0xFFFFFFFF gives 0xFFFFFFFF80000000.
  - remw of the same operands gives 0.
- Flush, reset and ignored starts:
  - Start mul, assert flush at T+10: IDLE at T+11, busy=0, no valid through T+70, result unchanged.
  - Repeat with rst=0 at T+10: all outputs 0 immediately.
  - start with mduop=0011 gives no busy.
  - start raised during MUL is ignored.
